dram_cmd_fsm: RTL and testbench
===============================

// Module: dram_cmd_fsm
// PURPOSE
//  DRAM command sequencer; sits directly upstream of timing_control and drives its cmd_state input.
//  Accepts one read/write request at a time from the scheduler. Tracks the open row per bank.
//  Issues the PRECHARGE / ACTIVATE / READ / WRITE / REFRESH sequence required for each request.
//  Advances out of each -ING wait state only on the matching t*_done from timing_control.
//  Services rf_req from timing_control with priority at transaction boundaries.
// PARAMETERS
//  BANK_BITS  4   bank index width (1<<BANK_BITS banks tracked)
//  ROW_BITS   16  row address width
//  COL_BITS   10  column address width
// PORTS
//  clk        in   1          single clock; all logic on posedge
//  RST        in   1          synchronous reset, active-high
//  req_valid  in   1          scheduler request valid
//  req_ready  out  1          request accepted on req_valid & req_ready
//  req_write  in   1          1=write, 0=read
//  req_bank   in   BANK_BITS  target bank
//  req_row    in   ROW_BITS   target row
//  req_col    in   COL_BITS   target column
//  tACT_done  in   1          from timing_control
//  tRD_done   in   1          from timing_control
//  tWR_done   in   1          from timing_control
//  tPRE_done  in   1          from timing_control
//  tREF_done  in   1          from timing_control
//  rf_req     in   1          refresh request from timing_control
//  cmd_state  out  cmd_state_t  current command state, to timing_control and the PHY command encoder
//  cmd_bank   out  BANK_BITS  bank of issued command (latched)
//  cmd_row    out  ROW_BITS   row of issued command (latched)
//  cmd_col    out  COL_BITS   column of issued command (latched)
//  pre_all    out  1          1 while in PRECHARGE/PRECHARGING for refresh (all-bank precharge)
//  rd_done    out  1          1-cycle pulse: read transaction complete
//  wr_done    out  1          1-cycle pulse: write transaction complete
// BEHAVIOUR
//  Reset values:
//   - cmd_state=IDLE; all open-row valid bits 0; cmd_bank/row/col=0
//   - pre_all=0, rd_done=0, wr_done=0, req_ready=0
//  req_ready = (cmd_state==IDLE) & ~rf_req & ~RST. It is combinational.
//  Request acceptance:
//   - On acceptance, latch write/bank/row/col into cmd_* that same edge.
//   - Classify against the open-row table in the same cycle:
//     hit -> READ/WRITE; bank closed -> ACTIVATE; bank open with a different row -> PRECHARGE.
//  Issue states are exactly 1 cycle each: ACTIVATE, READ, WRITE, PRECHARGE, REFRESH.
//   - Each then moves to its -ING state.
//  Wait-state exits; each -ING state holds until its done signal is sampled high:
//   - ACTIVATING  --tACT_done-->  READ or WRITE (per latched op)
//   - READING     --tRD_done-->   IDLE, rd_done=1 next cycle
//   - WRITING     --tWR_done-->   IDLE, wr_done=1 next cycle
//   - PRECHARGING --tPRE_done-->  REFRESH if pre_all, else ACTIVATE
//   - REFRESHING  --tREF_done-->  IDLE
//  Minimum latencies from acceptance edge to rd_done:
//   - row hit: 2 + (cycles until tRD_done)
//   - closed bank: additionally 1 + ACT wait
//  Refresh:
//   - In IDLE, rf_req beats req_valid; req_ready is low and no request is accepted.
//   - Any bank open -> PRECHARGE with pre_all=1; none open -> REFRESH directly.
//   - rf_req rising mid-transaction is ignored until the return to IDLE. No abort.
//  Open-row table updates:
//   - set valid[bank], row[bank] on the ACTIVATE issue cycle
//   - clear valid[bank] on a PRECHARGE issue with pre_all=0
//   - clear all valid bits on a PRECHARGE issue with pre_all=1
//   - REFRESH leaves all banks closed
//  Done inputs asserted outside their matching -ING state are ignored.
//  Reset mid-operation: next edge forces IDLE and clears the table. The latched request is dropped; no done pulse.
//  Illegal or unused cmd_state encodings recover to IDLE.
// STRUCTURE
//  dram_pkg:
//   - cmd_state_t enum (IDLE, ACTIVATE, ACTIVATING, READ, READING, WRITE, WRITING, PRECHARGE, PRECHARGING, REFRESH, REFRESHING), shared with timing_control
//   - timing constants tRCD, tRL, tWL, tRP, tRFC, tREFI stay in dram_pkg
//  Sub-module dram_row_tracker: per-bank valid+row table
//   - inputs: lookup port (bank,row -> hit/open), set port, clear-one port, clear-all port
//  Top level: next-state logic, request latch, done pulses. Expose cmd_state via command_fsm_if.
// TESTING
//  1. Empty table; read bank2 row 0x01A3 col 0x010; tACT_done 3 cycles later; tRD_done 5 cycles later
//     -> ACTIVATE(1), ACTIVATING, READ(1), READING, IDLE; rd_done one pulse; cmd_row=0x01A3
//  2. Then write bank2 row 0x01A3 -> row hit: WRITE issued the cycle after acceptance, no ACTIVATE; wr_done pulse after tWR_done
//  3. Then read bank2 row 0x01A4 -> PRECHARGE with pre_all=0, then ACTIVATE, then READ; table row[2]=0x01A4
//  4. Banks 2 and 5 open; rf_req=1 and req_valid=1 in IDLE -> req_ready=0; PRECHARGE pre_all=1, REFRESH, IDLE
//     -> table empty; the pending request is accepted afterwards
//  5. rf_req asserted during READING -> READING completes, rd_done pulses, then the refresh sequence; no READ aborted
//  6. RST=1 during WRITING -> cmd_state=IDLE next edge; table cleared; no wr_done; stray tACT_done in IDLE ignored

Source files
------------

// File: rtl/dram_pkg.sv
// Shared DRAM command-state encoding and timing constants.
package dram_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        ACTIVATE    = 4'd1,
        ACTIVATING  = 4'd2,
        READ        = 4'd3,
        READING     = 4'd4,
        WRITE       = 4'd5,
        WRITING     = 4'd6,
        PRECHARGE   = 4'd7,
        PRECHARGING = 4'd8,
        REFRESH     = 4'd9,
        REFRESHING  = 4'd10
    } cmd_state_t;

    // Timing constants consumed by timing_control (cycles).
    localparam int unsigned tRCD  = 4;
    localparam int unsigned tRL   = 5;
    localparam int unsigned tWL   = 4;
    localparam int unsigned tRP   = 4;
    localparam int unsigned tRFC  = 32;
    localparam int unsigned tREFI = 1560;

endpackage

// File: rtl/command_fsm_if.sv
// Bundle carrying the command state from the sequencer to timing_control.
interface command_fsm_if;
    import dram_pkg::*;

    cmd_state_t cmd_state;
    logic       pre_all;

    modport fsm (output cmd_state, output pre_all);
    modport tc  (input  cmd_state, input  pre_all);
endinterface

// File: rtl/dram_row_tracker.sv
// Per-bank open-row table: valid bit plus row address for each bank.
module dram_row_tracker #(
    parameter int unsigned BANK_BITS = 4,
    parameter int unsigned ROW_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [BANK_BITS-1:0] lk_bank,
    input  logic [ROW_BITS-1:0]  lk_row,
    output logic                 lk_open,
    output logic                 lk_hit,
    output logic                 any_open,
    input  logic                 set_en,
    input  logic [BANK_BITS-1:0] set_bank,
    input  logic [ROW_BITS-1:0]  set_row,
    input  logic                 clr_one_en,
    input  logic [BANK_BITS-1:0] clr_bank,
    input  logic                 clr_all_en
);
    localparam int unsigned NB = 1 << BANK_BITS;

    logic [NB-1:0]       valid;
    logic [ROW_BITS-1:0] row_tab [NB];

    // Valid bits: reset/clear-all wipe the table, clear-one closes a bank, set opens one.
    always_ff @(posedge clk) begin
        if (RST) begin
            valid <= '0;
        end else begin
            if (clr_all_en) begin
                valid <= '0;
            end else if (clr_one_en) begin
                valid[clr_bank] <= 1'b0;
            end
            if (set_en) begin
                valid[set_bank] <= 1'b1;
            end
        end
    end

    // Row addresses are only meaningful under their valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (set_en) begin
            row_tab[set_bank] <= set_row;
        end
    end

    assign lk_open  = valid[lk_bank];
    assign lk_hit   = lk_open && (row_tab[lk_bank] == lk_row);
    assign any_open = |valid;

endmodule

// File: rtl/dram_cmd_fsm.sv
// DRAM command sequencer: classifies requests against the open-row table
// and walks PRECHARGE/ACTIVATE/READ/WRITE/REFRESH handshaking with timing_control.
module dram_cmd_fsm
    import dram_pkg::*;
#(
    parameter int unsigned BANK_BITS = 4,
    parameter int unsigned ROW_BITS  = 16,
    parameter int unsigned COL_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BANK_BITS-1:0] req_bank,
    input  logic [ROW_BITS-1:0]  req_row,
    input  logic [COL_BITS-1:0]  req_col,
    input  logic                 tACT_done,
    input  logic                 tRD_done,
    input  logic                 tWR_done,
    input  logic                 tPRE_done,
    input  logic                 tREF_done,
    input  logic                 rf_req,
    output cmd_state_t           cmd_state,
    output logic [BANK_BITS-1:0] cmd_bank,
    output logic [ROW_BITS-1:0]  cmd_row,
    output logic [COL_BITS-1:0]  cmd_col,
    output logic                 pre_all,
    output logic                 rd_done,
    output logic                 wr_done
);
    cmd_state_t state, state_n;
    logic       cmd_write;
    logic       ref_mode, ref_mode_n;
    logic       accept;
    logic       lk_open, lk_hit, any_open;
    logic       set_en, clr_one_en, clr_all_en;

    command_fsm_if fsm_if ();

    dram_row_tracker #(
        .BANK_BITS (BANK_BITS),
        .ROW_BITS  (ROW_BITS)
    ) u_tracker (
        .clk        (clk),
        .RST        (RST),
        .lk_bank    (req_bank),
        .lk_row     (req_row),
        .lk_open    (lk_open),
        .lk_hit     (lk_hit),
        .any_open   (any_open),
        .set_en     (set_en),
        .set_bank   (cmd_bank),
        .set_row    (cmd_row),
        .clr_one_en (clr_one_en),
        .clr_bank   (cmd_bank),
        .clr_all_en (clr_all_en)
    );

    assign req_ready = (state == IDLE) & ~rf_req & ~RST;

    // Next-state, request acceptance and row-table update strobes.
    always_comb begin
        state_n    = state;
        ref_mode_n = ref_mode;
        accept     = 1'b0;
        set_en     = 1'b0;
        clr_one_en = 1'b0;
        clr_all_en = 1'b0;
        case (state)
            IDLE: begin
                if (rf_req) begin
                    ref_mode_n = 1'b1;
                    state_n    = any_open ? PRECHARGE : REFRESH;
                end else if (req_valid) begin
                    accept     = 1'b1;
                    ref_mode_n = 1'b0;
                    if (lk_hit)       state_n = req_write ? WRITE : READ;
                    else if (lk_open) state_n = PRECHARGE;
                    else              state_n = ACTIVATE;
                end
            end
            ACTIVATE: begin
                set_en  = 1'b1;
                state_n = ACTIVATING;
            end
            ACTIVATING:  if (tACT_done) state_n = cmd_write ? WRITE : READ;
            READ:        state_n = READING;
            READING:     if (tRD_done) state_n = IDLE;
            WRITE:       state_n = WRITING;
            WRITING:     if (tWR_done) state_n = IDLE;
            PRECHARGE: begin
                if (ref_mode) clr_all_en = 1'b1;
                else          clr_one_en = 1'b1;
                state_n = PRECHARGING;
            end
            PRECHARGING: if (tPRE_done) state_n = ref_mode ? REFRESH : ACTIVATE;
            REFRESH:     state_n = REFRESHING;
            REFRESHING: begin
                if (tREF_done) begin
                    state_n    = IDLE;
                    ref_mode_n = 1'b0;
                end
            end
            default:     state_n = IDLE;
        endcase
    end

    // State register, request latch and one-cycle completion pulses.
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            ref_mode  <= 1'b0;
            cmd_write <= 1'b0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            rd_done   <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            state    <= state_n;
            ref_mode <= ref_mode_n;
            if (accept) begin
                cmd_write <= req_write;
                cmd_bank  <= req_bank;
                cmd_row   <= req_row;
                cmd_col   <= req_col;
            end
            rd_done <= (state == READING) & tRD_done;
            wr_done <= (state == WRITING) & tWR_done;
        end
    end

    assign fsm_if.cmd_state = state;
    assign fsm_if.pre_all   = ref_mode & ((state == PRECHARGE) | (state == PRECHARGING));
    assign cmd_state        = fsm_if.cmd_state;
    assign pre_all          = fsm_if.pre_all;

endmodule

// File: tb/tb_dram_cmd_fsm.sv
// Directed bench for dram_cmd_fsm: request table plus refresh/reset sequences.
module tb_dram_cmd_fsm;
    import dram_pkg::*;

    logic        tb_CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_bank;
    logic [15:0] req_row;
    logic [9:0]  req_col;
    logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req;
    cmd_state_t  cmd_state;
    logic [3:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        pre_all, rd_done, wr_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
        cmd_state_t  first;
        int unsigned act_wait;
        int unsigned op_wait;
    } vec_t;

    vec_t vecs [6];

    dram_cmd_fsm #(
        .BANK_BITS (4),
        .ROW_BITS  (16),
        .COL_BITS  (10)
    ) dut (
        .clk       (tb_CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_bank  (req_bank),
        .req_row   (req_row),
        .req_col   (req_col),
        .tACT_done (tACT_done),
        .tRD_done  (tRD_done),
        .tWR_done  (tWR_done),
        .tPRE_done (tPRE_done),
        .tREF_done (tREF_done),
        .rf_req    (rf_req),
        .cmd_state (cmd_state),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .pre_all   (pre_all),
        .rd_done   (rd_done),
        .wr_done   (wr_done)
    );

    always #5 tb_CLK = ~tb_CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chk_st(input string name, input cmd_state_t want);
        chk(name, 32'(cmd_state), 32'(want));
    endtask

    task automatic step();
        @(posedge tb_CLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [3:0] bank, input logic [15:0] row,
                         input logic [9:0] col, input cmd_state_t first);
        req_write = wr;
        req_bank  = bank;
        req_row   = row;
        req_col   = col;
        req_valid = 1'b1;
        #1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge tb_CLK);
        #1;
        req_valid = 1'b0;
        chk_st("first_state", first);
        chk("cmd_bank", cmd_bank, bank);
        chk("cmd_row", cmd_row, row);
        chk("cmd_col", cmd_col, col);
    endtask

    // Walk from the first issued state to the completion pulse.
    task automatic follow(input cmd_state_t first, input logic wr,
                          input int unsigned act_wait, input int unsigned op_wait);
        cmd_state_t st;
        st = first;
        if (st == PRECHARGE) begin
            chk("pre_all_miss", pre_all, 0);
            step();
            chk_st("precharging", PRECHARGING);
            step();
            step();
            chk_st("precharging_hold", PRECHARGING);
            tPRE_done = 1'b1;
            step();
            tPRE_done = 1'b0;
            chk_st("act_after_pre", ACTIVATE);
            st = ACTIVATE;
        end
        if (st == ACTIVATE) begin
            step();
            chk_st("activating", ACTIVATING);
            for (int unsigned i = 1; i < act_wait; i++) step();
            chk_st("activating_hold", ACTIVATING);
            tACT_done = 1'b1;
            step();
            tACT_done = 1'b0;
            chk_st("op_after_act", wr ? WRITE : READ);
        end
        step();
        chk_st("op_wait", wr ? WRITING : READING);
        for (int unsigned i = 1; i < op_wait; i++) step();
        chk_st("op_wait_hold", wr ? WRITING : READING);
        chk("done_early", wr ? wr_done : rd_done, 0);
        if (wr) tWR_done = 1'b1;
        else    tRD_done = 1'b1;
        step();
        tWR_done = 1'b0;
        tRD_done = 1'b0;
        chk_st("idle_after_op", IDLE);
        chk("rd_done_pulse", rd_done, !wr);
        chk("wr_done_pulse", wr_done, wr);
        step();
        chk("rd_done_clear", rd_done, 0);
        chk("wr_done_clear", wr_done, 0);
    endtask

    task automatic refresh_tail(input logic via_pre);
        if (via_pre) begin
            chk_st("ref_precharge", PRECHARGE);
            chk("pre_all_ref", pre_all, 1);
            rf_req = 1'b0;
            step();
            chk_st("ref_precharging", PRECHARGING);
            chk("pre_all_ref_wait", pre_all, 1);
            tPRE_done = 1'b1;
            step();
            tPRE_done = 1'b0;
        end
        rf_req = 1'b0;
        chk_st("refresh", REFRESH);
        chk("pre_all_refresh", pre_all, 0);
        step();
        chk_st("refreshing", REFRESHING);
        tREF_done = 1'b1;
        step();
        tREF_done = 1'b0;
        chk_st("idle_after_ref", IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 4'd2, 16'h01A3, 10'h010, ACTIVATE,  3, 5};
        vecs[1] = '{1'b1, 4'd2, 16'h01A3, 10'h020, WRITE,     0, 3};
        vecs[2] = '{1'b0, 4'd2, 16'h01A4, 10'h030, PRECHARGE, 2, 2};
        vecs[3] = '{1'b0, 4'd2, 16'h01A4, 10'h031, READ,      0, 1};
        vecs[4] = '{1'b1, 4'd5, 16'h0777, 10'h001, ACTIVATE,  1, 4};
        vecs[5] = '{1'b0, 4'd5, 16'h0777, 10'h002, READ,      0, 2};

        RST = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
        tACT_done = 1'b0; tRD_done = 1'b0; tWR_done = 1'b0; tPRE_done = 1'b0;
        tREF_done = 1'b0; rf_req = 1'b0;
        step();
        step();
        chk_st("reset_state", IDLE);
        chk("reset_ready", req_ready, 0);
        chk("reset_pre_all", pre_all, 0);
        chk("reset_rd_done", rd_done, 0);
        chk("reset_wr_done", wr_done, 0);
        chk("reset_cmd_row", cmd_row, 0);
        RST = 1'b0;
        #1;
        chk("ready_after_reset", req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].wr, vecs[i].bank, vecs[i].row, vecs[i].col, vecs[i].first);
            follow(vecs[i].first, vecs[i].wr, vecs[i].act_wait, vecs[i].op_wait);
        end

        // Refresh beats a pending request; banks 2 and 5 open.
        rf_req = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_bank = 4'd5; req_row = 16'h0777; req_col = 10'h055;
        #1;
        chk("ready_rf_blocked", req_ready, 0);
        step();
        chk("cmd_col_not_taken", cmd_col, 10'h002);
        refresh_tail(1'b1);
        #1;
        chk("ready_after_ref", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk_st("pending_closed_bank", ACTIVATE);
        chk("pending_cmd_col", cmd_col, 10'h055);
        follow(ACTIVATE, 1'b0, 2, 2);

        // rf_req during READING must not abort the read.
        issue(1'b0, 4'd5, 16'h0777, 10'h066, READ);
        step();
        chk_st("reading_mid", READING);
        rf_req = 1'b1;
        step();
        step();
        chk_st("reading_rf_hold", READING);
        tRD_done = 1'b1;
        step();
        tRD_done = 1'b0;
        chk_st("idle_after_read_rf", IDLE);
        chk("rd_done_rf", rd_done, 1);
        chk("ready_rf_idle", req_ready, 0);
        step();
        chk("rd_done_rf_clear", rd_done, 0);
        refresh_tail(1'b1);

        // Refresh with no bank open goes straight to REFRESH.
        rf_req = 1'b1;
        step();
        refresh_tail(1'b0);

        // Reset during WRITING drops the transaction and the table.
        issue(1'b1, 4'd3, 16'h0100, 10'h00F, ACTIVATE);
        step();
        chk_st("activating_w", ACTIVATING);
        tACT_done = 1'b1;
        step();
        tACT_done = 1'b0;
        chk_st("write_w", WRITE);
        step();
        chk_st("writing_w", WRITING);
        RST = 1'b1;
        tWR_done = 1'b1;
        step();
        tWR_done = 1'b0;
        chk_st("idle_on_rst", IDLE);
        chk("wr_done_on_rst", wr_done, 0);
        chk("cmd_bank_on_rst", cmd_bank, 0);
        chk("ready_in_rst", req_ready, 0);
        RST = 1'b0;
        tACT_done = 1'b1;
        step();
        tACT_done = 1'b0;
        chk_st("stray_act_idle", IDLE);
        chk("wr_done_after_rst", wr_done, 0);
        issue(1'b1, 4'd3, 16'h0100, 10'h00F, ACTIVATE);
        follow(ACTIVATE, 1'b1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
